// File: rtl/sobel_frame_ctrl_if.sv
// Stream-side bundle of the Sobel frame controller: the source pixel handshake,
// the Sobel core pixel/clock-enable/edge link, and the marked edge output stream.
// The slave modport is the controller. The master modport is its surroundings:
// the pixel source, the Sobel core and the edge sink.
interface sobel_frame_ctrl_if #(
    parameter int PIX_W = 8
);
    logic             s_valid;
    logic [PIX_W-1:0] s_pixel;
    logic             s_ready;
    logic [PIX_W-1:0] core_pixel;
    logic             core_ce;
    logic             core_edge;
    logic             m_valid;
    logic             m_edge;
    logic             m_sof;
    logic             m_eol;
    logic             m_eof;

    modport master (
        output s_valid, s_pixel, core_edge,
        input  s_ready, core_pixel, core_ce,
        input  m_valid, m_edge, m_sof, m_eol, m_eof
    );

    modport slave (
        input  s_valid, s_pixel, core_edge,
        output s_ready, core_pixel, core_ce,
        output m_valid, m_edge, m_sof, m_eol, m_eof
    );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge core.
// It accepts one raster frame and gates the core with a clock enable. A tag pipe
// runs in step with the core pipeline. When a tag that belongs to a real pixel
// leaves the pipe, the controller emits the matching core_edge. That edge is
// border-masked and carries the SOF/EOL/EOF markers. At frame end the controller
// clocks dummy pixels through the core until the tag pipe holds no real tag.
module sobel_frame_ctrl #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int PIX_W    = 8,
    parameter int CORE_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    sobel_frame_ctrl_if.slave bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_ZERO = CW'(0);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_ZERO = RW'(0);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    in_col_r;
    logic [RW-1:0]    in_row_r;
    logic [CW-1:0]    out_col_r;
    logic [RW-1:0]    out_row_r;
    logic             ce_real_r;     // the pixel now presented on core_pixel is a real pixel
    logic [CORE_LAT:1] tp_r;         // tp_r[k]=1: core stage k holds a real pixel
    logic             s_ready_r;
    logic             core_ce_r;
    logic [PIX_W-1:0] core_pixel_r;
    logic             m_valid_r;
    logic             m_edge_r;
    logic             m_sof_r;
    logic             m_eol_r;
    logic             m_eof_r;
    logic             busy_r;
    logic             done_r;

    logic hs_s;
    logic last_in_s;
    logic emit_s;
    logic pipe_empty_s;
    logic out_eol_s;

    // The output position lies on the outermost ring of the frame.
    function automatic logic is_border(input logic [RW-1:0] row, input logic [CW-1:0] col);
        return (row == ROW_ZERO) || (row == ROW_LAST) || (col == COL_ZERO) || (col == COL_LAST);
    endfunction

    assign hs_s         = bus.s_valid & s_ready_r;
    assign last_in_s    = (in_col_r == COL_LAST) && (in_row_r == ROW_LAST);
    assign emit_s       = core_ce_r & tp_r[CORE_LAT];
    assign pipe_empty_s = ~ce_real_r && (tp_r == {CORE_LAT{1'b0}});
    assign out_eol_s    = (out_col_r == COL_LAST);

    // Frame FSM: input handshake, input raster counters and core pixel/enable drive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            in_col_r     <= COL_ZERO;
            in_row_r     <= ROW_ZERO;
            ce_real_r    <= 1'b0;
            s_ready_r    <= 1'b0;
            core_ce_r    <= 1'b0;
            core_pixel_r <= {PIX_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    core_ce_r <= 1'b0;
                    ce_real_r <= 1'b0;
                    done_r    <= 1'b0;
                    if (start) begin
                        state_r   <= S_STREAM;
                        s_ready_r <= 1'b1;
                        busy_r    <= 1'b1;
                        in_col_r  <= COL_ZERO;
                        in_row_r  <= ROW_ZERO;
                    end else begin
                        s_ready_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (hs_s) begin
                        core_pixel_r <= bus.s_pixel;
                        core_ce_r    <= 1'b1;
                        ce_real_r    <= 1'b1;
                        if (in_col_r == COL_LAST) begin
                            in_col_r <= COL_ZERO;
                            in_row_r <= in_row_r + ROW_ONE;
                        end else begin
                            in_col_r <= in_col_r + COL_ONE;
                        end
                        if (last_in_s) begin
                            state_r   <= S_FLUSH;
                            s_ready_r <= 1'b0;
                        end
                    end else begin
                        core_ce_r <= 1'b0;
                        ce_real_r <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    core_pixel_r <= {PIX_W{1'b0}};
                    ce_real_r    <= 1'b0;
                    if (pipe_empty_s) begin
                        state_r   <= S_DONE;
                        core_ce_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else begin
                        core_ce_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= S_IDLE;
                    s_ready_r <= 1'b0;
                    core_ce_r <= 1'b0;
                    ce_real_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipe tracking the core stages, plus the marked, border-masked edge output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tp_r      <= {CORE_LAT{1'b0}};
            out_col_r <= COL_ZERO;
            out_row_r <= ROW_ZERO;
            m_valid_r <= 1'b0;
            m_edge_r  <= 1'b0;
            m_sof_r   <= 1'b0;
            m_eol_r   <= 1'b0;
            m_eof_r   <= 1'b0;
        end else begin
            if (core_ce_r) begin
                tp_r[1] <= ce_real_r;
                for (int k = 2; k <= CORE_LAT; k++) begin
                    tp_r[k] <= tp_r[k-1];
                end
            end
            if (emit_s) begin
                m_valid_r <= 1'b1;
                m_edge_r  <= bus.core_edge & ~is_border(out_row_r, out_col_r);
                m_sof_r   <= (out_row_r == ROW_ZERO) && (out_col_r == COL_ZERO);
                m_eol_r   <= out_eol_s;
                m_eof_r   <= out_eol_s && (out_row_r == ROW_LAST);
                if (out_eol_s) begin
                    out_col_r <= COL_ZERO;
                    out_row_r <= out_row_r + ROW_ONE;
                end else begin
                    out_col_r <= out_col_r + COL_ONE;
                end
            end else begin
                m_valid_r <= 1'b0;
                m_edge_r  <= 1'b0;
                m_sof_r   <= 1'b0;
                m_eol_r   <= 1'b0;
                m_eof_r   <= 1'b0;
                if ((state_r == S_IDLE) && start) begin
                    out_col_r <= COL_ZERO;
                    out_row_r <= ROW_ZERO;
                end
            end
        end
    end

    assign bus.s_ready    = s_ready_r;
    assign bus.core_pixel = core_pixel_r;
    assign bus.core_ce    = core_ce_r;
    assign bus.m_valid    = m_valid_r;
    assign bus.m_edge     = m_edge_r;
    assign bus.m_sof      = m_sof_r;
    assign bus.m_eol      = m_eol_r;
    assign bus.m_eof      = m_eof_r;
    assign busy           = busy_r;
    assign done           = done_r;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on a reduced 16x12 frame with CORE_LAT=2.
// A small Sobel-core stand-in produces the parity of each captured pixel.
// Expected edges are computed per raster index from the frame rules.
module tb_sobel_frame_ctrl;
    localparam int W   = 16;
    localparam int H   = 12;
    localparam int N   = W * H;
    localparam int LAT = 2;

    typedef struct {
        int gap;        // 0: no stalls, >0: s_valid low every gap-th cycle, <0: random stalls
        bit cst;        // core_edge forced to 1
        bit extra;      // extra start pulses during STREAM and FLUSH
        bit rnd_pix;    // random pixels instead of i[7:0]
        bit chk_lat;    // check first-output latency
        bit save_t1;    // remember edge sequence as reference
        bit cmp_t1;     // compare edge sequence with the reference
        int exp_n;
        int exp_eol;
        int exp_ones;   // -1: take from the model
    } scen_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic const_mode = 1'b0;
    logic c1 = 1'b0;
    logic c2 = 1'b0;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    bit hs = 1'b0;
    bit prev_hs = 1'b0;
    int first_hs, first_mv, done_cnt, done_cyc, eof_cyc;
    logic [3:0] got_q[$];
    logic [7:0] px[N];
    logic       t1_edge[N];
    scen_t      tbl[5];

    always #5 clk = ~clk;

    sobel_frame_ctrl_if #(.PIX_W(8)) bus ();

    sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .CORE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    // Sobel core stand-in: a CORE_LAT-deep pipeline advancing only on core_ce.
    always @(posedge clk) begin
        if (bus.core_ce) begin
            c1 <= ^bus.core_pixel;
            c2 <= c1;
        end
    end
    assign bus.core_edge = const_mode ? 1'b1 : c2;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        hs = bus.s_valid && bus.s_ready;
        if (hs && first_hs < 0) first_hs = ncyc;
        if (bus.s_ready) check("core_ce_mirror", int'(bus.core_ce), int'(prev_hs));
        if (!bus.m_valid) begin
            check("marker_without_valid", int'({bus.m_edge, bus.m_sof, bus.m_eol, bus.m_eof}), 0);
        end else begin
            got_q.push_back({bus.m_edge, bus.m_sof, bus.m_eol, bus.m_eof});
            if (first_mv < 0) first_mv = ncyc;
            if (bus.m_eof) eof_cyc = ncyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        prev_hs = hs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        check(name, int'({bus.s_ready, bus.core_pixel, bus.core_ce, bus.m_valid, bus.m_edge,
                          bus.m_sof, bus.m_eol, bus.m_eof, busy, done}), 0);
    endtask

    task automatic run_frame(input scen_t s);
        int idx, cyc, guard, sof_n, eol_n, eof_n, ones_n, model_ones, diff;
        bit v;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; eof_cyc = -1; first_hs = -1; first_mv = -1;
        const_mode = s.cst;
        for (int i = 0; i < N; i++) px[i] = s.rnd_pix ? 8'($urandom) : 8'(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0; cyc = 0; guard = 0;
        while (idx < N && guard < 4 * N) begin
            if (s.gap == 0) v = 1'b1;
            else if (s.gap > 0) v = ((cyc % s.gap) != (s.gap - 1));
            else v = ($urandom_range(0, 3) != 0);
            bus.s_valid = v;
            bus.s_pixel = px[idx];
            start = s.extra && (idx == N / 2);
            tick();
            if (hs) idx++;
            cyc++; guard++;
        end
        check("pixels_accepted", idx, N);
        bus.s_valid = 1'b0;
        start = s.extra;
        tick();
        start = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 64) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        check("done_count", done_cnt, 1);
        check("done_after_eof", done_cyc - eof_cyc, 1);
        check("busy_after_frame", int'(busy), 0);
        check("out_count", got_q.size(), s.exp_n);
        sof_n = 0; eol_n = 0; eof_n = 0; ones_n = 0; model_ones = 0; diff = 0;
        for (int i = 0; i < N && i < got_q.size(); i++) begin
            int row, col;
            bit border, e;
            logic [3:0] exp;
            row = i / W;
            col = i % W;
            border = (row == 0) || (row == H - 1) || (col == 0) || (col == W - 1);
            e = s.cst ? 1'b1 : ^px[i];
            exp = {e & ~border, i == 0, col == W - 1, i == N - 1};
            model_ones += int'(exp[3]);
            check($sformatf("pix%0d", i), int'(got_q[i]), int'(exp));
            sof_n += int'(got_q[i][2]);
            eol_n += int'(got_q[i][1]);
            eof_n += int'(got_q[i][0]);
            ones_n += int'(got_q[i][3]);
            if (s.save_t1) t1_edge[i] = got_q[i][3];
            if (s.cmp_t1 && (t1_edge[i] != got_q[i][3])) diff++;
        end
        check("sof_count", sof_n, 1);
        check("eol_count", eol_n, s.exp_eol);
        check("eof_count", eof_n, 1);
        check("ones_count", ones_n, (s.exp_ones < 0) ? model_ones : s.exp_ones);
        if (s.chk_lat) begin
            check("first_latency", first_mv - first_hs, LAT + 2);
            if (got_q.size() > 0) check("first_is_sof", int'(got_q[0][2]), 1);
        end
        if (s.cmp_t1) check("edge_seq_vs_t1", diff, 0);
    endtask

    initial begin
        int idx;
        tbl[0] = '{gap: 0,  cst: 0, extra: 0, rnd_pix: 0, chk_lat: 1, save_t1: 1, cmp_t1: 0,
                   exp_n: N, exp_eol: H, exp_ones: -1};
        tbl[1] = '{gap: 3,  cst: 0, extra: 0, rnd_pix: 0, chk_lat: 0, save_t1: 0, cmp_t1: 1,
                   exp_n: N, exp_eol: H, exp_ones: -1};
        tbl[2] = '{gap: 0,  cst: 1, extra: 0, rnd_pix: 0, chk_lat: 1, save_t1: 0, cmp_t1: 0,
                   exp_n: N, exp_eol: H, exp_ones: (W - 2) * (H - 2)};
        tbl[3] = '{gap: 0,  cst: 0, extra: 1, rnd_pix: 1, chk_lat: 1, save_t1: 0, cmp_t1: 0,
                   exp_n: N, exp_eol: H, exp_ones: -1};
        tbl[4] = '{gap: -1, cst: 0, extra: 1, rnd_pix: 1, chk_lat: 0, save_t1: 0, cmp_t1: 0,
                   exp_n: N, exp_eol: H, exp_ones: -1};

        bus.s_valid = 1'b0;
        bus.s_pixel = 8'd0;
        first_hs = -1; first_mv = -1; done_cnt = 0; done_cyc = -1; eof_cyc = -1;
        repeat (3) tick();
        chk_zero("reset_state");
        rst = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) run_frame(tbl[k]);

        // Abort a frame halfway with reset, then run a clean frame.
        const_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        while (idx < N / 2) begin
            bus.s_valid = 1'b1;
            bus.s_pixel = 8'(idx * 7);
            tick();
            if (hs) idx++;
        end
        rst = 1'b0;
        tick();
        chk_zero("abort_reset_outputs");
        rst = 1'b1;
        bus.s_valid = 1'b0;
        got_q.delete();
        done_cnt = 0;
        repeat (20) tick();
        check("abort_no_output", got_q.size(), 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", int'({busy, bus.s_ready}), 0);
        run_frame(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
